// File: rtl/uart_rx.sv
// Oversampled UART receiver: start-edge detect, centre sampling, stop check.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err_o pulse.
module uart_rx #(
  parameter int DataWidth      = 8,
  parameter int OversampleRate = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 os_tick_i,
  input  logic                 rxd_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 dv_o,
  output logic                 frame_err_o,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err_o,
`endif
  output logic                 busy_o
);

  localparam int TickW = $clog2(OversampleRate);
  localparam int BitW  = (DataWidth > 1) ? $clog2(DataWidth) : 1;

  // Tick values are the counts *before* the strobe that performs the sample.
  localparam logic [TickW-1:0] HalfTick = TickW'(OversampleRate / 2 - 2);
  localparam logic [TickW-1:0] LastTick = TickW'(OversampleRate - 1);
  localparam logic [BitW-1:0]  LastBit  = BitW'(DataWidth - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {Idle, StartBit, DataBits, ParityBit, StopBit} state_e;
`else
  typedef enum logic [2:0] {Idle, StartBit, DataBits, StopBit} state_e;
`endif

  state_e               state_q, state_d;
  logic [TickW-1:0]     tick_cnt_q, tick_cnt_d, tick_next;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 dv_q, dv_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rxd_meta_q, rxd_meta_d;
  logic                 rxd_sync_q, rxd_sync_d;
  logic                 rxd_prev_q, rxd_prev_d;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit_q, parity_bit_d;
  logic                 parity_err_q, parity_err_d;
`endif

  assign tick_next = tick_cnt_q + TickW'(1);

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    dv_d        = 1'b0;
    frame_err_d = 1'b0;
    rxd_meta_d  = rxd_i;
    rxd_sync_d  = rxd_meta_q;
    rxd_prev_d  = rxd_sync_q;
`ifdef UART_RX_PARITY_EN
    parity_bit_d = parity_bit_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      Idle: begin
        if (rxd_prev_q && !rxd_sync_q) begin
          state_d    = StartBit;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end

      // A start bit that is high again at mid-bit is treated as a glitch.
      StartBit: begin
        if (os_tick_i) begin
          tick_cnt_d = tick_next;
          if (tick_cnt_q == HalfTick) begin
            if (rxd_sync_q) begin
              state_d = Idle;
            end else begin
              state_d    = DataBits;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end
          end
        end
      end

      DataBits: begin
        if (os_tick_i) begin
          tick_cnt_d = tick_next;
          if (tick_cnt_q == LastTick) begin
            shift_d   = {rxd_sync_q, shift_q} >> 1;
            bit_cnt_d = bit_cnt_q + BitW'(1);
            if (bit_cnt_q == LastBit) begin
              bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = ParityBit;
`else
              state_d = StopBit;
`endif
            end
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ParityBit: begin
        if (os_tick_i) begin
          tick_cnt_d = tick_next;
          if (tick_cnt_q == LastTick) begin
            parity_bit_d = rxd_sync_q;
            state_d      = StopBit;
          end
        end
      end
`endif

      StopBit: begin
        if (os_tick_i) begin
          tick_cnt_d = tick_next;
          if (tick_cnt_q == LastTick) begin
            state_d = Idle;
            if (rxd_sync_q) begin
              data_d = shift_q;
              dv_d   = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            parity_err_d = (^shift_q) ^ parity_bit_q;
`endif
          end
        end
      end

      default: state_d = Idle;
    endcase
  end

  // Synchronizer flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= Idle;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      dv_q        <= 1'b0;
      frame_err_q <= 1'b0;
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      rxd_prev_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      dv_q        <= dv_d;
      frame_err_q <= frame_err_d;
      rxd_meta_q  <= rxd_meta_d;
      rxd_sync_q  <= rxd_sync_d;
      rxd_prev_q  <= rxd_prev_d;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= parity_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_o      = data_q;
  assign dv_o        = dv_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = (state_q != Idle);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames, a queue of expected outcomes, and a
// per-cycle compare process that checks pulses and the held data word.
module tb_uart_rx;

  localparam int BitClk = 64;
`ifdef UART_RX_PARITY_EN
  localparam int FrameLen = 11;
`else
  localparam int FrameLen = 10;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       os_tick_i;
  logic       rxd_i;
  logic [7:0] data_o;
  logic       dv_o;
  logic       frame_err_o;
  logic       busy_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_o;
`endif

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    bit         par_err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_data;
  bit         started;
  int         total;
  int         bad;
  int         tick_phase;

  uart_rx #(.DataWidth(8), .OversampleRate(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .os_tick_i   (os_tick_i),
    .rxd_i       (rxd_i),
    .data_o      (data_o),
    .dv_o        (dv_o),
    .frame_err_o (frame_err_o),
`ifdef UART_RX_PARITY_EN
    .parity_err_o(parity_err_o),
`endif
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Oversample strobe: one clock high out of every four.
  initial begin
    os_tick_i  = 1'b0;
    tick_phase = 0;
    forever begin
      @(posedge clk_i);
      #1;
      tick_phase = (tick_phase + 1) % 4;
      os_tick_i  = (tick_phase == 0);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic logic [15:0] makeFrame(input logic [7:0] d, input logic stop, input logic par);
    logic [15:0] f;
`ifdef UART_RX_PARITY_EN
    f = {5'b0, stop, par, d, 1'b0};
`else
    f = {6'b0, stop, d, 1'b0};
    if (par) f = f;
`endif
    return f;
  endfunction

  task automatic applyStimulus(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rxd_i = bits[i];
      waitClk(BitClk);
    end
  endtask

  // Queue the outcome the receiver must report, then drive the whole frame.
  task automatic sendFrame(input logic [7:0] d, input logic stop, input logic par);
    exp_t e;
    e.is_err  = !stop;
    e.data    = d;
    e.par_err = (^d) ^ par;
    exp_q.push_back(e);
    applyStimulus(makeFrame(d, stop, par), FrameLen);
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n;
    n = 0;
    while (busy_o && n < budget) begin
      waitClk(1);
      n++;
    end
    checkOutput(name, {31'b0, busy_o}, 32'd0);
  endtask

  always @(negedge clk_i) begin
    if (started && !rst_i) begin
      exp_t e;
      checkOutput("pulse_exclusive", {31'b0, dv_o & frame_err_o}, 32'd0);
      if (dv_o || frame_err_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pulse", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pulse_kind_ferr", {31'b0, frame_err_o}, {31'b0, e.is_err});
          if (!e.is_err) model_data = e.data;
`ifdef UART_RX_PARITY_EN
          checkOutput("parity_err", {31'b0, parity_err_o}, {31'b0, e.par_err});
`endif
        end
      end else begin
`ifdef UART_RX_PARITY_EN
        checkOutput("parity_err_idle", {31'b0, parity_err_o}, 32'd0);
`endif
      end
      checkOutput("data_o_held", {24'b0, data_o}, {24'b0, model_data});
    end
  end

  initial begin
    logic [15:0] f;
    total      = 0;
    bad        = 0;
    started    = 0;
    model_data = 8'h00;
    rxd_i      = 1'b1;
    rst_i      = 1'b1;
    waitClk(5);
    checkOutput("reset_data", {24'b0, data_o}, 32'h0);
    checkOutput("reset_dv", {31'b0, dv_o}, 32'd0);
    checkOutput("reset_ferr", {31'b0, frame_err_o}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy_o}, 32'd0);
    rst_i   = 1'b0;
    started = 1;
    waitClk(20);

    $display("[TB] frame 0x55");
    sendFrame(8'h55, 1'b1, ^8'h55);
    waitClk(BitClk);
    waitIdle("idle_after_55", 2000);
    checkOutput("consumed_55", 32'(exp_q.size()), 32'd0);
    checkOutput("data_55", {24'b0, data_o}, 32'h55);

    $display("[TB] start glitch");
    rxd_i = 1'b0;
    waitClk(10);
    checkOutput("glitch_busy_high", {31'b0, busy_o}, 32'd1);
    waitClk(10);
    rxd_i = 1'b1;
    waitClk(100);
    checkOutput("glitch_busy_low", {31'b0, busy_o}, 32'd0);
    checkOutput("glitch_data", {24'b0, data_o}, 32'h55);

    $display("[TB] frame 0xA3 bad stop, line held low");
    sendFrame(8'hA3, 1'b0, ^8'hA3);
    waitClk(1000);
    checkOutput("low_no_retrigger", {31'b0, busy_o}, 32'd0);
    checkOutput("consumed_a3", 32'(exp_q.size()), 32'd0);
    checkOutput("data_after_ferr", {24'b0, data_o}, 32'h55);
    rxd_i = 1'b1;
    waitClk(200);
    checkOutput("rise_no_trigger", {31'b0, busy_o}, 32'd0);

    $display("[TB] back-to-back 0x00 0xFF");
    sendFrame(8'h00, 1'b1, ^8'h00);
    sendFrame(8'hFF, 1'b1, ^8'hFF);
    rxd_i = 1'b1;
    waitClk(BitClk);
    waitIdle("idle_after_b2b", 2000);
    checkOutput("consumed_b2b", 32'(exp_q.size()), 32'd0);
    checkOutput("data_ff", {24'b0, data_o}, 32'hFF);

    $display("[TB] reset mid-frame 0x3C");
    f = makeFrame(8'h3C, 1'b1, ^8'h3C);
    applyStimulus(f, 5);
    rxd_i = f[5];
    waitClk(BitClk / 2);
    checkOutput("midframe_busy", {31'b0, busy_o}, 32'd1);
    rst_i      = 1'b1;
    model_data = 8'h00;
    waitClk(1);
    checkOutput("rst_data", {24'b0, data_o}, 32'h0);
    checkOutput("rst_busy", {31'b0, busy_o}, 32'd0);
    checkOutput("rst_dv", {31'b0, dv_o}, 32'd0);
    checkOutput("rst_ferr", {31'b0, frame_err_o}, 32'd0);
    waitClk(3);
    rst_i = 1'b0;
    rxd_i = 1'b1;
    waitClk(2 * BitClk);
    checkOutput("post_rst_idle", {31'b0, busy_o}, 32'd0);
    sendFrame(8'h81, 1'b1, ^8'h81);
    waitClk(BitClk);
    waitIdle("idle_after_81", 2000);
    checkOutput("data_81", {24'b0, data_o}, 32'h81);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity frames 0x07");
    sendFrame(8'h07, 1'b1, 1'b0);
    waitClk(BitClk);
    waitIdle("idle_after_par0", 2000);
    checkOutput("data_07", {24'b0, data_o}, 32'h07);
    sendFrame(8'h07, 1'b1, 1'b1);
    waitClk(BitClk);
    waitIdle("idle_after_par1", 2000);
`endif

    checkOutput("all_consumed", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
